// File: rtl/ripple_sampler_if.sv
// +--------------------------------------------------------------------------+
// | Module      : ripple_sampler_if                                          |
// | Description : Ripple-bit input and settled-count valid/ready bundle.     |
// |               Optional delta output under RIPPLE_SAMPLER_DELTA_EN.       |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
`default_nettype none

interface ripple_sampler_if #(
  parameter int WIDTH = 5
);

  logic [WIDTH-1:0] ripple_in;
  logic             out_ready;
  logic [WIDTH-1:0] count;
  logic             count_valid;
  logic             wrap_pulse;
  logic             lost;
`ifdef RIPPLE_SAMPLER_DELTA_EN
  logic [WIDTH-1:0] delta;

  modport master (
    output ripple_in,
    output out_ready,
    input  count,
    input  count_valid,
    input  wrap_pulse,
    input  lost,
    input  delta
  );

  modport slave (
    input  ripple_in,
    input  out_ready,
    output count,
    output count_valid,
    output wrap_pulse,
    output lost,
    output delta
  );
`else
  modport master (
    output ripple_in,
    output out_ready,
    input  count,
    input  count_valid,
    input  wrap_pulse,
    input  lost
  );

  modport slave (
    input  ripple_in,
    input  out_ready,
    output count,
    output count_valid,
    output wrap_pulse,
    output lost
  );
`endif

endinterface : ripple_sampler_if

`default_nettype wire

// File: rtl/ripple_sampler.sv
// +--------------------------------------------------------------------------+
// | Module      : ripple_sampler                                             |
// | Description : Synchronises asynchronous ripple-counter bits, waits out   |
// |               ripple settling and publishes each settled count once over |
// |               valid/ready, with wrap detection and a sticky lost flag.   |
// |               Macro RIPPLE_SAMPLER_DELTA_EN adds the delta output.       |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
`default_nettype none

module ripple_sampler #(
  parameter int WIDTH         = 5,
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 2
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  ripple_sampler_if.slave   bus
);

  localparam int CNT_W = $clog2(STABLE_CYCLES + 2);

  localparam logic [1:0] ST_WAIT   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_COMMIT = 2'd2;

  // ------------------------------------------------------------------------
  // Synchroniser chain; the only logic that sees ripple_in
  // ------------------------------------------------------------------------
  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= bus.ripple_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  // ------------------------------------------------------------------------
  // Settle FSM
  // ------------------------------------------------------------------------
  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] cand_q,  cand_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [CNT_W-1:0] cnt_inc;
  logic [WIDTH-1:0] base_q,  base_d;
  logic             commit;

  assign cnt_inc = cnt_q + CNT_W'(1);
  assign commit  = (state_q == ST_COMMIT);

  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    base_d  = base_q;
    case (state_q)
      ST_WAIT: begin
        if (s != base_q) begin
          cand_d  = s;
          cnt_d   = CNT_W'(1);
          state_d = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (s != cand_q) begin
          cand_d = s;
          cnt_d  = CNT_W'(1);
        end else begin
          cnt_d = cnt_inc;
          // A glitch that settles back onto the baseline is not a new sample
          if (cnt_inc >= CNT_W'(STABLE_CYCLES)) begin
            state_d = (cand_q == base_q) ? ST_WAIT : ST_COMMIT;
          end
        end
      end
      ST_COMMIT: begin
        base_d  = cand_q;
        state_d = ST_WAIT;
      end
      default: begin
        state_d = ST_WAIT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_WAIT;
      cand_q  <= '0;
      cnt_q   <= '0;
      base_q  <= '0;
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
      base_q  <= base_d;
    end
  end

  // ------------------------------------------------------------------------
  // Output register and handshake
  // ------------------------------------------------------------------------
  logic [WIDTH-1:0] count_q, count_d;
  logic             valid_q, valid_d;
  logic             wrap_q,  wrap_d;
  logic             lost_q,  lost_d;

  always_comb begin
    count_d = count_q;
    valid_d = valid_q;
    wrap_d  = 1'b0;
    lost_d  = lost_q;
    if (commit) begin
      // A commit always reloads; an unaccepted sample is overwritten
      count_d = cand_q;
      valid_d = 1'b1;
      wrap_d  = (cand_q < base_q);
      if (valid_q && !bus.out_ready) begin
        lost_d = 1'b1;
      end
    end else if (valid_q && bus.out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
      lost_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      valid_q <= valid_d;
      wrap_q  <= wrap_d;
      lost_q  <= lost_d;
    end
  end

  assign bus.count       = count_q;
  assign bus.count_valid = valid_q;
  assign bus.wrap_pulse  = wrap_q;
  assign bus.lost        = lost_q;

`ifdef RIPPLE_SAMPLER_DELTA_EN
  logic [WIDTH-1:0] delta_q, delta_d;

  always_comb begin
    delta_d = delta_q;
    if (commit) begin
      delta_d = cand_q - base_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      delta_q <= '0;
    end else begin
      delta_q <= delta_d;
    end
  end

  assign bus.delta = delta_q;
`endif

endmodule : ripple_sampler

`default_nettype wire
